// File: rtl/narrow_32_16.sv
// Narrows a signed 32-bit word onto a 16-bit valid/ready stream, either as one
// range-checked halfword (narrow) or as two beats, low half first (split).
module narrow_32_16 #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAST = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] data_reg, data_next;
    logic [15:0] pend_reg, pend_next;
    logic        ovf_reg, ovf_next;
    logic        last_reg, last_next;

    logic        accept;
    logic        fits;
    logic [15:0] narrow_data;

    // The word fits in signed 16 bits when bits 31..15 are all copies of the sign.
    assign fits = (&in_data[31:15]) | ~(|in_data[31:15]);

    generate
        if (SATURATE) begin : g_sat
            assign narrow_data = fits ? in_data[15:0]
                                      : (in_data[31] ? 16'h8000 : 16'h7FFF);
        end else begin : g_trunc
            assign narrow_data = in_data[15:0];
        end
    endgenerate

    // In LAST a new word may enter only while the held beat leaves.
    assign in_ready  = rst_n & ((state_reg == IDLE) | ((state_reg == LAST) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg != IDLE);
    assign out_data  = data_reg;
    assign out_ovf   = ovf_reg;
    assign out_last  = last_reg;

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        pend_next  = pend_reg;
        ovf_next   = ovf_reg;
        last_next  = last_reg;

        case (state_reg)
            IDLE: ;
            LO: begin
                if (out_ready) begin
                    data_next  = pend_reg;
                    ovf_next   = 1'b0;
                    last_next  = 1'b1;
                    state_next = LAST;
                end
            end
            LAST: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Accept is only possible from IDLE or a draining LAST, so it overrides.
        if (accept) begin
            if (in_mode) begin
                data_next  = in_data[15:0];
                pend_next  = in_data[31:16];
                ovf_next   = 1'b0;
                last_next  = 1'b0;
                state_next = LO;
            end else begin
                data_next  = narrow_data;
                ovf_next   = ~fits;
                last_next  = 1'b1;
                state_next = LAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= 16'h0000;
            pend_reg  <= 16'h0000;
            ovf_reg   <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: tb/tb_narrow_32_16.sv
// Bench for narrow_32_16: saturating and truncating instances share stimulus;
// table vectors, directed split/backpressure/reset sequences, random streaming.
module tb_narrow_32_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_out_ovf, s_out_last;
    logic [15:0] s_out_data;
    logic        t_in_ready, t_out_valid, t_out_ovf, t_out_last;
    logic [15:0] t_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    narrow_32_16 #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .out_last(s_out_last)
    );

    narrow_32_16 #(.SATURATE(1'b0)) u_trunc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(t_in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_data(t_out_data), .out_ovf(t_out_ovf), .out_last(t_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: range test by signed integer comparison.
    task automatic ref_narrow(input logic [31:0] d, input bit sat,
                              output logic [15:0] r, output bit ovf);
        int v;
        v   = $signed(d);
        ovf = (v > 32767) || (v < -32768);
        if (ovf && sat) r = (v < 0) ? 16'h8000 : 16'h7FFF;
        else            r = d[15:0];
    endtask

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp_sat;
        logic [15:0] exp_trn;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] d_sat;
        logic [15:0] d_trn;
        logic        ovf;
        logic        last;
    } beat_t;

    vec_t  vecs[8];
    beat_t q[$];

    task automatic chk_both(input string name, input logic [15:0] es, input logic [15:0] et,
                            input logic eovf, input logic elast);
        chk({name, ".valid"}, {31'd0, s_out_valid}, 32'd1);
        chk({name, ".data"},  {16'd0, s_out_data},  {16'd0, es});
        chk({name, ".ovf"},   {31'd0, s_out_ovf},   {31'd0, eovf});
        chk({name, ".last"},  {31'd0, s_out_last},  {31'd0, elast});
        chk({name, ".tdata"}, {16'd0, t_out_data},  {16'd0, et});
        chk({name, ".tovf"},  {31'd0, t_out_ovf},   {31'd0, eovf});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r_sat, r_trn;
        bit          r_ovf;
        logic [31:0] w[4];
        logic        prev_in_valid, prev_out_ready, prev_mode;
        logic [31:0] prev_data;
        bit          exp_rdy, acc;
        beat_t       b;

        vecs[0] = '{32'hFFFF_8000, 16'h8000, 16'h8000, 1'b0};
        vecs[1] = '{32'h0000_7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[2] = '{32'h0001_0000, 16'h7FFF, 16'h0000, 1'b1};
        vecs[3] = '{32'h8000_0000, 16'h8000, 16'h0000, 1'b1};
        vecs[4] = '{32'hFFFF_7FFF, 16'h8000, 16'h7FFF, 1'b1};
        vecs[5] = '{32'h0000_8000, 16'h7FFF, 16'h8000, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[7] = '{32'h0000_0000, 16'h0000, 16'h0000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, sampled while reset is still asserted
        chk("rst.valid", {31'd0, s_out_valid}, 32'd0);
        chk("rst.data",  {16'd0, s_out_data},  32'd0);
        chk("rst.ovf",   {31'd0, s_out_ovf},   32'd0);
        chk("rst.last",  {31'd0, s_out_last},  32'd0);
        chk("rst.ready", {31'd0, s_in_ready},  32'd0);
        rst_n = 1'b1;

        // Table-driven narrow vectors, one word at a time from IDLE
        foreach (vecs[i]) begin
            @(negedge clk);
            chk("tbl.idle_ready", {31'd0, s_in_ready}, 32'd1);
            in_valid = 1'b1; in_data = vecs[i].din; in_mode = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk_both($sformatf("tbl%0d", i), vecs[i].exp_sat, vecs[i].exp_trn, vecs[i].exp_ovf, 1'b1);
            $display("vec %0d: in=%h sat=%h trn=%h ovf=%b", i, vecs[i].din, s_out_data, t_out_data, s_out_ovf);
            @(negedge clk);
            chk("tbl.drained", {31'd0, s_out_valid}, 32'd0);
        end

        // Split at full rate
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_both("split.lo", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        chk("split.lo_ready", {31'd0, s_in_ready}, 32'd0);
        @(negedge clk);
        chk_both("split.hi", 16'hDEAD, 16'hDEAD, 1'b0, 1'b1);
        $display("split: hi beat %h last=%b", s_out_data, s_out_last);
        @(negedge clk);
        chk("split.drained", {31'd0, s_out_valid}, 32'd0);

        // Backpressure on the low beat
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_both("bp.hold", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
            chk("bp.ready", {31'd0, s_in_ready}, 32'd0);
            @(negedge clk);
        end
        chk_both("bp.hold_end", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_both("bp.hi", 16'hDEAD, 16'hDEAD, 1'b0, 1'b1);
        $display("backpressure: released, hi beat %h", s_out_data);
        @(negedge clk);
        chk("bp.drained", {31'd0, s_out_valid}, 32'd0);

        // Four narrow words back to back
        w[0] = 32'h0000_1234; w[1] = 32'hFFFF_FFFE; w[2] = 32'h7000_0000; w[3] = 32'hFFFF_8001;
        out_ready = 1'b1; in_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = w[k];
            @(negedge clk);
            ref_narrow(w[k], 1'b1, r_sat, r_ovf);
            ref_narrow(w[k], 1'b0, r_trn, r_ovf);
            chk_both($sformatf("tput%0d", k), r_sat, r_trn, r_ovf, 1'b1);
            chk("tput.ready", {31'd0, s_in_ready}, 32'd1);
            $display("stream %0d: in=%h out=%h ovf=%b", k, w[k], s_out_data, s_out_ovf);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tput.drained", {31'd0, s_out_valid}, 32'd0);

        // Reset while the low beat of a split is held
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk_both("rs.lo", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs.valid", {31'd0, s_out_valid}, 32'd0);
        chk("rs.data",  {16'd0, s_out_data},  32'd0);
        chk("rs.ready", {31'd0, s_in_ready},  32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rs.no_hi", {31'd0, s_out_valid}, 32'd0);
        end
        chk("rs.idle_ready", {31'd0, s_in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 32'h0000_0042; in_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk_both("rs.new", 16'h0042, 16'h0042, 1'b0, 1'b1);
        $display("reset mid-split: new word out=%h", s_out_data);

        // Random streaming against a beat-queue model
        do_reset();
        q.delete();
        prev_in_valid = 1'b0; prev_out_ready = 1'b0; prev_mode = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            // Replay the handshake that happened at the last rising edge
            exp_rdy = (q.size() == 0) || (q.size() == 1 && prev_out_ready);
            acc = prev_in_valid && exp_rdy;
            if (q.size() != 0 && prev_out_ready) void'(q.pop_front());
            if (acc) begin
                if (prev_mode) begin
                    b = '{prev_data[15:0], prev_data[15:0], 1'b0, 1'b0};
                    q.push_back(b);
                    b = '{prev_data[31:16], prev_data[31:16], 1'b0, 1'b1};
                    q.push_back(b);
                end else begin
                    ref_narrow(prev_data, 1'b1, r_sat, r_ovf);
                    ref_narrow(prev_data, 1'b0, r_trn, r_ovf);
                    b = '{r_sat, r_trn, r_ovf, 1'b1};
                    q.push_back(b);
                end
            end
            chk("rnd.valid", {31'd0, s_out_valid}, {31'd0, q.size() != 0});
            chk("rnd.ready", {31'd0, s_in_ready},
                {31'd0, (q.size() == 0) || (q.size() == 1 && out_ready)});
            if (q.size() != 0) begin
                chk_both("rnd", q[0].d_sat, q[0].d_trn, q[0].ovf, q[0].last);
            end

            prev_in_valid  = ($urandom_range(0, 3) != 0);
            prev_out_ready = ($urandom_range(0, 3) != 0);
            prev_mode      = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: prev_data = $urandom;
                1: begin
                    prev_data[15:0]  = $urandom;
                    prev_data[31:16] = {16{prev_data[15]}};
                end
                2: prev_data = $urandom_range(0, 1) ? (32'h0000_7FF8 + $urandom_range(0, 15))
                                                    : (32'hFFFF_7FF8 + $urandom_range(0, 15));
                default: prev_data = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            endcase
            in_valid = prev_in_valid; out_ready = prev_out_ready;
            in_mode = prev_mode; in_data = prev_data;
        end
        $display("random: 3000 cycles streamed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
